// File: rtl/ram_sp_bus_master_if.sv
// Host-side handshake bundle for ram_sp_bus_master: request channel,
// write-beat channel and read-beat stream.
interface ram_sp_bus_master_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 8,
   parameter int LEN_W  = 6
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [LEN_W-1:0]  req_len;
   logic              wdata_valid;
   logic              wdata_ready;
   logic [DATA_W-1:0] wdata;
   logic              rdata_valid;
   logic [DATA_W-1:0] rdata;

   modport master (
      output req_valid, req_write, req_addr, req_len, wdata_valid, wdata,
      input  req_ready, wdata_ready, rdata_valid, rdata
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_len, wdata_valid, wdata,
      output req_ready, wdata_ready, rdata_valid, rdata
   );
endinterface

// File: rtl/ram_sp_bus_master.sv
// Initiator for the 64x8 single-port RAM: turns host burst requests into
// registered RAM pin sequences and streams read data back to the host.
module ram_sp_bus_master #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 8,
   parameter int LEN_W  = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   ram_sp_bus_master_if.slave   host,
   output logic                 ram_cs,
   output logic                 ram_wr_en,
   output logic                 ram_o_en,
   output logic [ADDR_W-1:0]    ram_rd_adrs,
   output logic [ADDR_W-1:0]    ram_wr_adrs,
   inout  wire  [DATA_W-1:0]    ram_data
);

   typedef enum logic [1:0] {IDLE, WR, RD} state_e;

   localparam logic [LEN_W:0] ONE = 1;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] start_q, start_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W:0]    cnt_q, cnt_d;
   logic              cs_q, cs_d;
   logic              wr_en_q, wr_en_d;
   logic              o_en_q, o_en_d;
   logic [ADDR_W-1:0] rd_adrs_q, rd_adrs_d;
   logic [ADDR_W-1:0] wr_adrs_q, wr_adrs_d;
   logic [DATA_W-1:0] wdat_q, wdat_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              rdata_valid_q, rdata_valid_d;

   logic [LEN_W:0]    len_x;
   logic [ADDR_W-1:0] beat_adrs;

   assign len_x     = {1'b0, len_q};
   assign beat_adrs = start_q + ADDR_W'(cnt_q);

   always_comb begin
      state_d       = state_q;
      start_d       = start_q;
      len_d         = len_q;
      cnt_d         = cnt_q;
      cs_d          = 1'b0;
      wr_en_d       = 1'b0;
      o_en_d        = 1'b0;
      rd_adrs_d     = rd_adrs_q;
      wr_adrs_d     = wr_adrs_q;
      wdat_d        = wdat_q;
      // The bus is captured at the end of every output-enable cycle.
      rdata_valid_d = o_en_q;
      rdata_d       = o_en_q ? ram_data : rdata_q;

      case (state_q)
         IDLE: begin
            if (host.req_valid) begin
               start_d = host.req_addr;
               len_d   = host.req_len;
               if (host.req_write) begin
                  state_d = WR;
                  cnt_d   = '0;
               end else begin
                  // Beat 0 address phase is issued straight from acceptance.
                  state_d   = RD;
                  cnt_d     = ONE;
                  cs_d      = 1'b1;
                  rd_adrs_d = host.req_addr;
               end
            end
         end
         WR: begin
            if (host.wdata_valid) begin
               cs_d      = 1'b1;
               wr_en_d   = 1'b1;
               wr_adrs_d = beat_adrs;
               wdat_d    = host.wdata;
               cnt_d     = cnt_q + ONE;
               if (cnt_q == len_x) state_d = IDLE;
            end
         end
         RD: begin
            // cnt_q counts address phases issued; one extra slot covers
            // the trailing data phase with the last address held.
            if (cnt_q <= len_x) begin
               cs_d      = 1'b1;
               o_en_d    = 1'b1;
               rd_adrs_d = beat_adrs;
               cnt_d     = cnt_q + ONE;
            end else if (cnt_q == len_x + ONE) begin
               cs_d   = 1'b1;
               o_en_d = 1'b1;
               cnt_d  = cnt_q + ONE;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         start_q       <= '0;
         len_q         <= '0;
         cnt_q         <= '0;
         cs_q          <= 1'b0;
         wr_en_q       <= 1'b0;
         o_en_q        <= 1'b0;
         rd_adrs_q     <= '0;
         wr_adrs_q     <= '0;
         wdat_q        <= '0;
         rdata_q       <= '0;
         rdata_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         start_q       <= start_d;
         len_q         <= len_d;
         cnt_q         <= cnt_d;
         cs_q          <= cs_d;
         wr_en_q       <= wr_en_d;
         o_en_q        <= o_en_d;
         rd_adrs_q     <= rd_adrs_d;
         wr_adrs_q     <= wr_adrs_d;
         wdat_q        <= wdat_d;
         rdata_q       <= rdata_d;
         rdata_valid_q <= rdata_valid_d;
      end
   end

   assign ram_cs      = cs_q;
   assign ram_wr_en   = wr_en_q;
   assign ram_o_en    = o_en_q;
   assign ram_rd_adrs = rd_adrs_q;
   assign ram_wr_adrs = wr_adrs_q;
   assign ram_data    = wr_en_q ? wdat_q : {DATA_W{1'bz}};

   assign host.req_ready   = (state_q == IDLE);
   assign host.wdata_ready = (state_q == WR);
   assign host.rdata_valid = rdata_valid_q;
   assign host.rdata       = rdata_q;

endmodule

// File: tb/tb_ram_sp_bus_master.sv
// Bench for ram_sp_bus_master: behavioural RAM on the pins, an array
// reference of memory contents, and cycle-exact burst expectations.
module tb_ram_sp_bus_master;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ram_cs, ram_wr_en, ram_o_en;
   logic [5:0] ram_rd_adrs, ram_wr_adrs;
   wire  [7:0] ram_data;

   int total = 0;
   int bad   = 0;

   logic [7:0] mem_ref [64] = '{default: 8'h00};
   logic [7:0] ram_mem [64] = '{default: 8'h00};
   logic [7:0] ram_q = 8'h00;
   logic [7:0] wbuf   [64];
   int         gapbuf [64];

   ram_sp_bus_master_if bus ();

   ram_sp_bus_master dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .host        (bus),
      .ram_cs      (ram_cs),
      .ram_wr_en   (ram_wr_en),
      .ram_o_en    (ram_o_en),
      .ram_rd_adrs (ram_rd_adrs),
      .ram_wr_adrs (ram_wr_adrs),
      .ram_data    (ram_data)
   );

   always #5 clk = ~clk;

   // Behavioural RAM: registered read, output only while o_en is high.
   always @(posedge clk) begin
      if (ram_cs && ram_wr_en) ram_mem[ram_wr_adrs] <= ram_data;
      if (ram_cs && !ram_wr_en) ram_q <= ram_mem[ram_rd_adrs];
   end
   assign ram_data = ram_o_en ? ram_q : 8'hzz;

   always @(negedge clk) begin
      if (rst_n) begin
         total++;
         if ((ram_o_en && ram_wr_en) || (ram_wr_en && !ram_cs) ||
             ((ram_o_en || ram_wr_en) && $isunknown(ram_data))) begin
            bad++;
            $display("FAIL bus_turnaround o_en=%0b wr_en=%0b cs=%0b data=%h", ram_o_en, ram_wr_en, ram_cs, ram_data);
         end
      end
   end

   task automatic do_write(input logic [5:0] a, input int n);
      int plan_b[$];
      logic [5:0] ea;
      plan_b = {};
      for (int i = 0; i < n; i++) begin
         for (int g = 0; g < gapbuf[i]; g++) plan_b.push_back(-1);
         plan_b.push_back(i);
      end
      total++;
      if (bus.req_ready !== 1'b1) begin
         bad++; $display("FAIL wr_req_ready got=%b want=1", bus.req_ready);
      end
      bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = a; bus.req_len = 6'(n - 1);
      @(negedge clk);
      bus.req_valid = 1'b0;
      for (int c = 0; c < plan_b.size(); c++) begin
         total++;
         if (bus.wdata_ready !== 1'b1 || bus.req_ready !== 1'b0) begin
            bad++; $display("FAIL wr_handshake c=%0d wdata_ready=%b req_ready=%b want 1/0", c, bus.wdata_ready, bus.req_ready);
         end
         if (plan_b[c] >= 0) begin
            bus.wdata_valid = 1'b1; bus.wdata = wbuf[plan_b[c]];
         end else begin
            bus.wdata_valid = 1'b0; bus.wdata = 8'($urandom);
         end
         @(negedge clk);
         total++;
         if (plan_b[c] < 0) begin
            if (ram_wr_en !== 1'b0) begin
               bad++; $display("FAIL wr_stall c=%0d wr_en=%b want=0", c, ram_wr_en);
            end
         end else begin
            ea = a + 6'(plan_b[c]);
            if (ram_wr_en !== 1'b1 || ram_cs !== 1'b1 || ram_o_en !== 1'b0 ||
                ram_wr_adrs !== ea || ram_data !== wbuf[plan_b[c]]) begin
               bad++;
               $display("FAIL wr_pulse beat=%0d got cs/we/oe=%b%b%b adr=%h dat=%h want 110 adr=%h dat=%h",
                        plan_b[c], ram_cs, ram_wr_en, ram_o_en, ram_wr_adrs, ram_data, ea, wbuf[plan_b[c]]);
            end
            mem_ref[ea] = wbuf[plan_b[c]];
         end
      end
      bus.wdata_valid = 1'b0;
      total++;
      if (bus.req_ready !== 1'b1) begin
         bad++; $display("FAIL wr_done_ready got=%b want=1", bus.req_ready);
      end
   endtask

   task automatic do_read(input logic [5:0] a, input int n);
      logic [5:0] ea;
      logic [4:0] want;
      total++;
      if (bus.req_ready !== 1'b1) begin
         bad++; $display("FAIL rd_req_ready got=%b want=1", bus.req_ready);
      end
      bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = a; bus.req_len = 6'(n - 1);
      for (int k = 1; k <= n + 2; k++) begin
         @(negedge clk);
         bus.req_valid = 1'b0;
         want = {1'(k <= n + 1), 1'(k >= 2 && k <= n + 1), 1'b0, 1'(k == n + 2), 1'(k >= 3)};
         total++;
         if ({ram_cs, ram_o_en, ram_wr_en, bus.req_ready, bus.rdata_valid} !== want) begin
            bad++;
            $display("FAIL rd_ctrl k=%0d cs/oe/we/rdy/rv got=%b want=%b", k,
                     {ram_cs, ram_o_en, ram_wr_en, bus.req_ready, bus.rdata_valid}, want);
         end
         if (k <= n + 1) begin
            ea = a + 6'((k <= n) ? k - 1 : n - 1);
            total++;
            if (ram_rd_adrs !== ea) begin
               bad++; $display("FAIL rd_adrs k=%0d got=%h want=%h", k, ram_rd_adrs, ea);
            end
         end
         if (k >= 3) begin
            ea = a + 6'(k - 3);
            total++;
            if (bus.rdata !== mem_ref[ea]) begin
               bad++; $display("FAIL rd_data beat=%0d adr=%h got=%h want=%h", k - 3, ea, bus.rdata, mem_ref[ea]);
            end
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_len = '0;
      bus.wdata_valid = 1'b0; bus.wdata = '0;
      for (int i = 0; i < 64; i++) gapbuf[i] = 0;
      @(negedge clk); @(negedge clk);
      total++;
      if ({ram_cs, ram_wr_en, ram_o_en, bus.rdata_valid} !== 4'b0 || ram_rd_adrs !== 6'h0 ||
          ram_wr_adrs !== 6'h0 || bus.rdata !== 8'h0) begin
         bad++; $display("FAIL reset_state cs/we/oe/rv=%b%b%b%b rd=%h wr=%h rdata=%h want all 0",
                         ram_cs, ram_wr_en, ram_o_en, bus.rdata_valid, ram_rd_adrs, ram_wr_adrs, bus.rdata);
      end
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (bus.req_ready !== 1'b1 || bus.rdata_valid !== 1'b0) begin
         bad++; $display("FAIL reset_release rdy=%b rv=%b want 1/0", bus.req_ready, bus.rdata_valid);
      end
      // Start a read, then pull reset between clock edges.
      bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 6'd7; bus.req_len = 6'd3;
      @(negedge clk);
      bus.req_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({ram_cs, ram_wr_en, ram_o_en, bus.rdata_valid} !== 4'b0 || ram_rd_adrs !== 6'h0 || ram_wr_adrs !== 6'h0) begin
         bad++; $display("FAIL reset_async cs/we/oe/rv=%b%b%b%b rd=%h wr=%h want all 0",
                         ram_cs, ram_wr_en, ram_o_en, bus.rdata_valid, ram_rd_adrs, ram_wr_adrs);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (bus.req_ready !== 1'b1 || bus.rdata_valid !== 1'b0 || ram_cs !== 1'b0) begin
         bad++; $display("FAIL reset_after rdy=%b rv=%b cs=%b want 1/0/0", bus.req_ready, bus.rdata_valid, ram_cs);
      end
   endtask

   task automatic test_single;
      wbuf[0] = 8'hA5; gapbuf[0] = 0;
      do_write(6'd5, 1);
      do_read(6'd5, 1);
   endtask

   task automatic test_wrap_gaps;
      wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
      gapbuf[0] = 0; gapbuf[1] = 0; gapbuf[2] = 2; gapbuf[3] = 0;
      do_write(6'h3E, 4);
      gapbuf[2] = 0;
      do_read(6'h3E, 4);
   endtask

   task automatic test_full_read;
      for (int i = 0; i < 64; i++) begin
         wbuf[i] = 8'($urandom); gapbuf[i] = 0;
      end
      do_write(6'd0, 64);
      do_read(6'd0, 64);
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 4; i++) begin
         wbuf[i] = 8'($urandom); gapbuf[i] = 0;
      end
      do_read(6'd20, 3);
      do_write(6'd21, 2);
      do_read(6'd20, 3);
   endtask

   task automatic test_random;
      logic [5:0] a;
      int n;
      for (int it = 0; it < 30; it++) begin
         a = 6'($urandom);
         n = $urandom_range(1, 8);
         if ($urandom_range(0, 1) == 1) begin
            for (int i = 0; i < n; i++) begin
               wbuf[i] = 8'($urandom);
               gapbuf[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            end
            do_write(a, n);
         end else begin
            do_read(a, n);
         end
      end
   endtask

   task automatic test_reset_mid;
      bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 6'd30; bus.req_len = 6'd5;
      repeat (3) begin
         @(negedge clk);
         bus.req_valid = 1'b0;
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({ram_cs, ram_wr_en, ram_o_en, bus.rdata_valid} !== 4'b0) begin
         bad++; $display("FAIL reset_mid cs/we/oe/rv got=%b%b%b%b want=0000", ram_cs, ram_wr_en, ram_o_en, bus.rdata_valid);
      end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         total++;
         if (ram_cs !== 1'b0 || bus.rdata_valid !== 1'b0) begin
            bad++; $display("FAIL reset_mid_quiet k=%0d cs=%b rv=%b want 0/0", k, ram_cs, bus.rdata_valid);
         end
      end
      wbuf[0] = 8'h5C; gapbuf[0] = 0;
      do_write(6'd9, 1);
      do_read(6'd9, 1);
   endtask

   initial begin
      test_reset();
      test_single();
      test_wrap_gaps();
      test_full_read();
      test_back_to_back();
      test_random();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ram_sp_bus_master.md
Name: ram_sp_bus_master

Overview:
- Initiator-side controller for the team's 64x8 single-port RAM.
- The RAM interface has:
  - chip select, write enable and output enable;
  - separate read and write addresses;
  - a shared bidirectional 8-bit data bus.
- The RAM's read data is registered inside the RAM, so read data appears on the bus one cycle after the read cycle, and only while output enable is high.
- This block accepts single or burst read/write requests from a host over valid/ready handshakes, sequences the RAM control pins, owns bus turnaround, and returns read data as a stream.

Parameters:
- ADDR_W, 6, RAM address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 8, data bus width.
- LEN_W, 6, burst length field width; burst = req_len+1 beats (1..2^LEN_W).

Ports:
- clk  input  1  Single clock; all logic on posedge.
- rst_n  input  1  Asynchronous active-low reset.
- req_valid  input  1  Host request valid.
- req_ready  output  1  Controller can accept a request.
- req_write  input  1  1 = write burst, 0 = read burst.
- req_addr  input  ADDR_W  Burst start address.
- req_len  input  LEN_W  Beats minus one.
- wdata_valid  input  1  Write beat valid.
- wdata_ready  output  1  Write beat accepted this cycle if valid.
- wdata  input  DATA_W  Write beat data.
- rdata_valid  output  1  Read beat valid; single-cycle pulse per beat, no backpressure.
- rdata  output  DATA_W  Read beat data.
- ram_cs  output  1  RAM chip select.
- ram_wr_en  output  1  RAM write enable.
- ram_o_en  output  1  RAM output enable.
- ram_rd_adrs  output  ADDR_W  RAM read address.
- ram_wr_adrs  output  ADDR_W  RAM write address.
- ram_data  inout  DATA_W  Shared data bus.

Behaviour:
- Reset:
  - rst_n low forces, asynchronously:
    - state IDLE;
    - ram_cs, ram_wr_en, ram_o_en, rdata_valid = 0;
    - rdata, ram_rd_adrs, ram_wr_adrs = 0;
    - ram_data released (hi-Z).
  - A reset mid-burst aborts the burst. No further RAM cycles occur, and no stale rdata_valid appears after release.
- Register rules:
  - All RAM-side outputs are registered; none is combinational from host inputs.
  - ram_data is driven with the registered write data iff registered ram_wr_en = 1; otherwise hi-Z.
- FSM: IDLE, WR, RD.
- IDLE:
  - req_ready = 1.
  - On req_valid: latch the start address and beat count.
  - Go to WR if req_write = 1, else RD. Acceptance cycle = t0.
- WR:
  - wdata_ready = 1.
  - A beat accepted (wdata_valid & wdata_ready) in cycle t produces, in cycle t+1:
    - ram_cs = 1, ram_wr_en = 1, ram_o_en = 0;
    - ram_wr_adrs = start+beat;
    - ram_data = that beat's data.
  - Cycles without an accepted beat leave ram_cs/ram_wr_en = 0 in the following cycle (stall, no write).
  - After the last beat is accepted, the next state is IDLE. The final write pulse overlaps that IDLE cycle, and a request accepted there is legal.
- RD (pipelined, one beat per cycle, no stalls):
  - Beat i address phase is cycle t0+1+i: ram_cs = 1, ram_wr_en = 0, ram_rd_adrs = start+i.
  - Beat i data phase is cycle t0+2+i: ram_o_en = 1, ram_cs = 1. The controller samples ram_data at the end of that cycle.
  - rdata_valid = 1 with rdata = beat i in cycle t0+3+i.
  - For an N-beat burst:
    - ram_cs is high over cycles t0+1..t0+N+1;
    - ram_o_en is high over cycles t0+2..t0+N+1;
    - during the last data phase, ram_rd_adrs holds the last address (the re-read is harmless);
    - state returns to IDLE so that cycle t0+N+2 has ram_cs = ram_o_en = 0 and req_ready = 1;
    - rdata_valid last pulses in cycle t0+N+2.
  - Read latency is 3 cycles from acceptance to the first rdata_valid.
- Turnaround:
  - A write's bus drive never begins before the cycle after ram_o_en falls.
  - ram_o_en & ram_wr_en is never 1.
  - The bus is never driven by both ends.
- Address arithmetic:
  - start+beat is computed modulo 2^ADDR_W.
  - Example: start 62, 3 beats -> 62, 63, 0.
- Write-then-read ordering: a write committed in cycle t+1 followed by a read of the same address returns the new data.

Test Plan:
- Reset: assert rst_n = 0 mid-cycle -> all RAM controls 0, ram_data = Z, req_ready = 1 after release, rdata_valid = 0.
- Single write then single read:
  - Write addr 5, data 0xA5.
  - Then read addr 5, accepted at t0.
  - Required: rdata_valid in cycle t0+3 with rdata = 0xA5.
- Wrapping write burst with gaps:
  - Write burst start 0x3E, req_len = 3, data 11, 22, 33, 44.
  - wdata_valid is low for 2 cycles between beats 2 and 3.
  - Required: exactly 4 write pulses, to addresses 0x3E, 0x3F, 0x00, 0x01.
  - A following read burst with the same start and length returns 11, 22, 33, 44 on 4 consecutive rdata_valid cycles.
- Full-length read:
  - Read burst req_len = 63 from 0.
  - Required: 64 consecutive rdata_valid pulses and req_ready low throughout.
  - The next cycle after the last o_en has ram_cs = ram_o_en = 0 before any new bus activity.
- Direction change:
  - Read immediately followed by write.
  - Required: assertion monitors see no cycle with ram_o_en & ram_wr_en, and no X on ram_data while o_en or wr_en is high.
- Reset mid-burst:
  - Assert reset during beat 2 of a 6-beat read.
  - Required: rdata_valid and RAM controls drop immediately.
  - After release, a single write/read to addr 9 (0x5C) completes normally.
